// File: rtl/lcd_feed_pkg.sv
// Shared types and constants for the MCU-to-LCD word feeder.
//   lcd_word_t   : one LCD word, {is_data, byte_val}
//   FRAME_BITS   : SPI frame length in bits
//   DEF_SYNC_NIBBLE : default value required in frame bits [15:12]
//   feed_state_t : output FSM states
package lcd_feed_pkg;

   localparam int FRAME_BITS = 16;
   localparam logic [3:0] DEF_SYNC_NIBBLE = 4'hA;

   typedef struct packed {
      logic       is_data;
      logic [7:0] byte_val;
   } lcd_word_t;

   typedef enum logic {
      IDLE,
      HOLD
   } feed_state_t;

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous FIFO of LCD words.
// Ports:
//   Clock, Reset      : system clock, async active-low reset
//   push, wr_data     : write request and word
//   pop               : read request; rd_data shows the head word combinationally
//   full, empty, level: occupancy status
// A push while full is accepted only if a pop happens in the same cycle.
module lcd_word_fifo
   import lcd_feed_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   push,
   input  lcd_word_t              wr_data,
   input  logic                   pop,
   output lcd_word_t              rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   lcd_word_t       mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Extra pointer MSB distinguishes full from empty when the addresses match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/mcu_lcd_feeder.sv
// Receives 16-bit LCD frames from the MCU over mode-0 SPI, buffers the
// 9-bit words and presents each on from_MCU for HOLD_CYCLES clocks so the
// slow LCD domain samples every word exactly once.
// Ports:
//   Clock, Reset      : system clock, async active-low reset
//   sclk, mosi, cs_n  : asynchronous SPI pins from the MCU
//   clr_flags         : pulse clearing overflow and frame_err
//   from_MCU          : word to LCD_Logic, [8] data/command, [7:0] byte
//   word_valid        : high while from_MCU is inside its hold slot
//   fifo_level        : FIFO occupancy
//   overflow          : sticky, valid frame dropped on a full FIFO
//   frame_err         : sticky, malformed or truncated frame discarded
//
// Output FSM
//   state | meaning
//   IDLE  | no word in a hold slot; pop as soon as the FIFO has one
//   HOLD  | from_MCU held; hold_cnt counts down to the end of the slot
module mcu_lcd_feeder
   import lcd_feed_pkg::*;
#(
   parameter int         HOLD_CYCLES = 131200,
   parameter int         DEPTH       = 8,
   parameter logic [3:0] SYNC_NIBBLE = DEF_SYNC_NIBBLE
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   sclk,
   input  logic                   mosi,
   input  logic                   cs_n,
   input  logic                   clr_flags,
   output logic [8:0]             from_MCU,
   output logic                   word_valid,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   overflow,
   output logic                   frame_err
);

   localparam int BCW = $clog2(FRAME_BITS);
   localparam int HCW = $clog2(HOLD_CYCLES);
   localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

   logic [1:0]            sclk_sync, mosi_sync, cs_sync;
   logic                  sclk_d, cs_d;
   logic                  sclk_rise, cs_fall, cs_rise;
   logic [FRAME_BITS-2:0] shift_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [BCW-1:0]        bit_cnt;
   logic                  frame_vld;
   logic                  trunc_err;
   logic                  frame_ok;
   logic                  push, pop, drop_full, bad_frame;
   logic                  fifo_full, fifo_empty;
   lcd_word_t             rd_data;
   feed_state_t           state;
   logic [HCW-1:0]        hold_cnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         cs_sync   <= 2'b11;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[0], sclk};
         mosi_sync <= {mosi_sync[0], mosi};
         cs_sync   <= {cs_sync[0], cs_n};
         sclk_d    <= sclk_sync[1];
         cs_d      <= cs_sync[1];
      end
   end

   assign sclk_rise = sclk_sync[1] && !sclk_d;
   assign cs_fall   = !cs_sync[1] && cs_d;
   assign cs_rise   = cs_sync[1] && !cs_d;

   // The completed frame is registered and checked one cycle later, so the
   // FIFO push lands 4 clocks after the last sclk edge reaches the pin.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         shift_q   <= '0;
         frame_q   <= '0;
         bit_cnt   <= '0;
         frame_vld <= 1'b0;
         trunc_err <= 1'b0;
      end else begin
         frame_vld <= 1'b0;
         trunc_err <= 1'b0;
         if (cs_fall) begin
            bit_cnt <= '0;
         end else if (cs_rise) begin
            if (bit_cnt != '0) trunc_err <= 1'b1;
            bit_cnt <= '0;
         end else if (!cs_sync[1] && sclk_rise) begin
            shift_q <= {shift_q[FRAME_BITS-3:0], mosi_sync[1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BCW'(FRAME_BITS - 1)) begin
               frame_q   <= {shift_q, mosi_sync[1]};
               frame_vld <= 1'b1;
            end
         end
      end
   end

   assign frame_ok  = (frame_q[15:12] == SYNC_NIBBLE) && (frame_q[11:9] == 3'b000);
   assign push      = frame_vld && frame_ok && (!fifo_full || pop);
   assign drop_full = frame_vld && frame_ok && fifo_full && !pop;
   assign bad_frame = (frame_vld && !frame_ok) || trunc_err;

   lcd_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clock   (Clock),
      .Reset   (Reset),
      .push    (push),
      .wr_data (lcd_word_t'(frame_q[8:0])),
      .pop     (pop),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // A new error outranks a simultaneous clear.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (drop_full)      overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;
         if (bad_frame)      frame_err <= 1'b1;
         else if (clr_flags) frame_err <= 1'b0;
      end
   end

   always_comb begin
      pop = 1'b0;
      if (state == IDLE)          pop = !fifo_empty;
      else if (hold_cnt == '0)    pop = !fifo_empty;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         from_MCU   <= '0;
         word_valid <= 1'b0;
      end else if (pop) begin
         from_MCU   <= rd_data;
         word_valid <= 1'b1;
         hold_cnt   <= HOLD_LOAD;
         state      <= HOLD;
      end else if (state == HOLD) begin
         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end else begin
            word_valid <= 1'b0;
            state      <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mcu_lcd_feeder.sv
// Bench for mcu_lcd_feeder. Instance a uses a 10-cycle hold slot; instance b
// uses a long slot so the FIFO can be filled and overflowed by SPI traffic.
module tb_mcu_lcd_feeder;

   localparam int HOLD_A = 10;
   localparam int HOLD_B = 2000;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_a = 1'b1;
   logic       cs_b = 1'b1;
   logic       clr_flags = 1'b0;

   logic [8:0] from_a, from_b;
   logic       valid_a, valid_b;
   logic [3:0] level_a, level_b;
   logic       ovf_a, ovf_b, ferr_a, ferr_b;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [8:0] q_a[$];
   logic [8:0] q_b[$];
   int         falls_b = 0;

   typedef struct {
      logic [15:0] frame;
      bit          exp_err;
   } vec_t;
   vec_t vecs[7];

   always #5 Clock = ~Clock;

   mcu_lcd_feeder #(.HOLD_CYCLES(HOLD_A), .DEPTH(8), .SYNC_NIBBLE(4'hA)) u_dut_a (
      .Clock(Clock), .Reset(Reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_a),
      .clr_flags(clr_flags), .from_MCU(from_a), .word_valid(valid_a),
      .fifo_level(level_a), .overflow(ovf_a), .frame_err(ferr_a)
   );

   mcu_lcd_feeder #(.HOLD_CYCLES(HOLD_B), .DEPTH(8), .SYNC_NIBBLE(4'hA)) u_dut_b (
      .Clock(Clock), .Reset(Reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_b),
      .clr_flags(clr_flags), .from_MCU(from_b), .word_valid(valid_b),
      .fifo_level(level_b), .overflow(ovf_b), .frame_err(ferr_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a slot starts when word_valid rises or the previous
   // slot has run its full length; each slot start pops one expected word.
   initial begin
      int         hc = 0;
      logic       pv = 1'b0;
      logic [8:0] last = '0;
      forever begin
         @(negedge Clock);
         if (!Reset) begin
            hc = 0;
            pv = 1'b0;
         end else begin
            if (valid_a && (!pv || hc == HOLD_A)) begin
               if (q_a.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL a_unexpected_word: got %0h, expected none", from_a);
               end else begin
                  check("a_word", from_a, q_a.pop_front());
               end
               last = from_a;
               hc = 1;
            end else if (valid_a) begin
               hc++;
               check("a_stable", from_a, last);
            end else if (pv) begin
               check("a_hold_len", hc, HOLD_A);
               check("a_retain", from_a, last);
            end
            pv = valid_a;
         end
      end
   end

   initial begin
      int         hc = 0;
      logic       pv = 1'b0;
      logic [8:0] last = '0;
      forever begin
         @(negedge Clock);
         if (!Reset) begin
            hc = 0;
            pv = 1'b0;
         end else begin
            if (valid_b && (!pv || hc == HOLD_B)) begin
               if (q_b.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL b_unexpected_word: got %0h, expected none", from_b);
               end else begin
                  check("b_word", from_b, q_b.pop_front());
               end
               last = from_b;
               hc = 1;
            end else if (valid_b) begin
               hc++;
               if (from_b !== last) check("b_stable", from_b, last);
            end else if (pv) begin
               falls_b++;
               check("b_hold_len", hc, HOLD_B);
            end
            pv = valid_b;
         end
      end
   end

   // Shifts nbits of f MSB first; with chk_lat, measures push latency and
   // the following pop on instance a after the last bit.
   task automatic spi_bits(input logic [15:0] f, input int nbits, input bit chk_lat);
      for (int i = 0; i < nbits; i++) begin
         @(negedge Clock);
         mosi = f[15-i];
         sclk = 1'b0;
         repeat (4) @(negedge Clock);
         sclk = 1'b1;
         if (chk_lat && i == nbits - 1) begin
            int lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
               @(posedge Clock);
               #1;
               if (level_a != 0) lat = k;
            end
            check("a_push_latency", lat, 4);
            @(posedge Clock);
            #1;
            check("a_level_after_pop", level_a, 0);
            check("a_valid_after_pop", valid_a, 1);
            check("a_word_after_pop", from_a, 9'h105);
         end
         repeat (4) @(negedge Clock);
      end
      @(negedge Clock);
      sclk = 1'b0;
      repeat (4) @(negedge Clock);
   endtask

   task automatic pulse_clr();
      @(negedge Clock);
      clr_flags = 1'b1;
      @(negedge Clock);
      clr_flags = 1'b0;
      @(negedge Clock);
   endtask

   initial begin
      vecs[0] = '{16'hA1FF, 1'b0};
      vecs[1] = '{16'h5105, 1'b1};
      vecs[2] = '{16'hA3FF, 1'b1};
      vecs[3] = '{16'hA0AA, 1'b0};
      vecs[4] = '{16'hB000, 1'b1};
      vecs[5] = '{16'hAE00, 1'b1};
      vecs[6] = '{16'hA000, 1'b0};

      repeat (3) @(negedge Clock);
      check("rst_from", from_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_level", level_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_ferr", ferr_a, 0);
      Reset = 1'b1;

      repeat (20) begin
         @(negedge Clock);
         check("idle_from", from_a, 0);
         check("idle_valid", valid_a, 0);
         check("idle_level", level_a, 0);
      end

      // Single frame with latency measurement.
      q_a.push_back(9'h105);
      cs_a = 1'b0;
      repeat (4) @(negedge Clock);
      spi_bits(16'hA105, 16, 1'b1);
      cs_a = 1'b1;
      repeat (20) @(negedge Clock);
      check("a105_from_kept", from_a, 9'h105);
      check("a105_valid_low", valid_a, 0);

      // Table of single frames, good and malformed.
      for (int v = 0; v < 7; v++) begin
         logic [15:0] f;
         f = vecs[v].frame;
         if (!vecs[v].exp_err) q_a.push_back(f[8:0]);
         cs_a = 1'b0;
         repeat (4) @(negedge Clock);
         spi_bits(f, 16, 1'b0);
         cs_a = 1'b1;
         repeat (20) @(negedge Clock);
         check("tbl_ferr", ferr_a, vecs[v].exp_err);
         check("tbl_level", level_a, 0);
         pulse_clr();
         check("tbl_ferr_clr", ferr_a, 0);
      end

      // Three frames within one chip-select window.
      q_a.push_back(9'h03C);
      q_a.push_back(9'h006);
      q_a.push_back(9'h001);
      cs_a = 1'b0;
      repeat (4) @(negedge Clock);
      spi_bits(16'hA03C, 16, 1'b0);
      spi_bits(16'hA006, 16, 1'b0);
      spi_bits(16'hA001, 16, 1'b0);
      cs_a = 1'b1;
      repeat (20) @(negedge Clock);
      check("seq_ferr", ferr_a, 0);
      check("seq_sb_empty", q_a.size(), 0);

      // Truncated frame: 12 bits then chip-select release.
      cs_a = 1'b0;
      repeat (4) @(negedge Clock);
      spi_bits(16'hA123, 12, 1'b0);
      cs_a = 1'b1;
      repeat (10) @(negedge Clock);
      check("trunc_ferr", ferr_a, 1);
      check("trunc_level", level_a, 0);
      check("trunc_valid", valid_a, 0);
      pulse_clr();
      check("trunc_ferr_clr", ferr_a, 0);

      // Overflow on the long-slot instance: word 0 pops at once, words 1..8
      // fill the FIFO, word 9 is dropped.
      cs_b = 1'b0;
      repeat (4) @(negedge Clock);
      for (int i = 0; i < 10; i++) begin
         logic [15:0] f;
         f = 16'hA100 | 16'(i);
         if (i < 9) q_b.push_back(f[8:0]);
         spi_bits(f, 16, 1'b0);
      end
      cs_b = 1'b1;
      repeat (10) @(negedge Clock);
      check("ovf_level", level_b, 8);
      check("ovf_flag", ovf_b, 1);
      check("ovf_ferr", ferr_b, 0);
      check("ovf_other_inst", ovf_a, 0);
      pulse_clr();
      check("ovf_clr", ovf_b, 0);

      begin
         int waited = 0;
         while (q_b.size() > 3 && waited < 20000) begin
            @(negedge Clock);
            waited++;
         end
         if (q_b.size() > 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected, expected 3", q_b.size());
         end
      end
      repeat (50) @(negedge Clock);
      check("b2b_valid", valid_b, 1);
      check("b2b_level", level_b, 3);
      check("b2b_no_gap", falls_b, 0);

      // Asynchronous reset in the middle of a hold slot.
      #3;
      Reset = 1'b0;
      q_b.delete();
      #1;
      check("areset_from", from_b, 0);
      check("areset_valid", valid_b, 0);
      check("areset_level", level_b, 0);
      check("areset_ovf", ovf_b, 0);
      check("areset_ferr", ferr_b, 0);
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      repeat (100) begin
         @(negedge Clock);
         check("post_rst_valid", valid_b, 0);
         check("post_rst_from", from_b, 0);
         check("post_rst_level", level_b, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
